// File: rtl/skinny_subcells_ctrl.sv
// SubCells sequencer for a 3-share SKINNY-64 datapath: streams nibbles MSN-first into an
// external pipelined Sbox of latency LAT and reassembles the returned nibbles in order.
module skinny_subcells_ctrl #(
    parameter int unsigned LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] st_in1,
    input  logic [63:0] st_in2,
    input  logic [63:0] st_in3,
    input  logic        load,
    input  logic        start,
    output logic [3:0]  sb_in1,
    output logic [3:0]  sb_in2,
    output logic [3:0]  sb_in3,
    input  logic [3:0]  sb_out1,
    input  logic [3:0]  sb_out2,
    input  logic [3:0]  sb_out3,
    output logic        rnd_en,
    output logic [63:0] st_out1,
    output logic [63:0] st_out2,
    output logic [63:0] st_out3,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [4:0] LastCyc   = 5'(15 + LAT);
    localparam logic [4:0] CollFirst = 5'(LAT);

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [63:0] feed1_q, feed2_q, feed3_q;
    logic [63:0] coll1_q, coll2_q, coll3_q;
    logic        feed_phase;
    logic        coll_phase;

    assign feed_phase = (state_q == StRun) && (cnt_q < 5'd16);
    // Upper bound is implicit: RUN never lasts past cnt_q == LastCyc.
    assign coll_phase = (state_q == StRun) && (cnt_q >= CollFirst);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            feed1_q <= 64'd0;
            feed2_q <= 64'd0;
            feed3_q <= 64'd0;
            coll1_q <= 64'd0;
            coll2_q <= 64'd0;
            coll3_q <= 64'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    cnt_q <= 5'd0;
                    if (load) begin
                        feed1_q <= st_in1;
                        feed2_q <= st_in2;
                        feed3_q <= st_in3;
                    end
                    if (start) state_q <= StRun;
                end
                StRun: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LastCyc) state_q <= StDone;
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase

            // Shares are shifted independently; nothing ever mixes two shares.
            if (feed_phase) begin
                feed1_q <= {feed1_q[59:0], 4'h0};
                feed2_q <= {feed2_q[59:0], 4'h0};
                feed3_q <= {feed3_q[59:0], 4'h0};
            end
            if (coll_phase) begin
                coll1_q <= {coll1_q[59:0], sb_out1};
                coll2_q <= {coll2_q[59:0], sb_out2};
                coll3_q <= {coll3_q[59:0], sb_out3};
            end
        end
    end

    assign sb_in1  = feed_phase ? feed1_q[63:60] : 4'h0;
    assign sb_in2  = feed_phase ? feed2_q[63:60] : 4'h0;
    assign sb_in3  = feed_phase ? feed3_q[63:60] : 4'h0;
    assign rnd_en  = feed_phase;
    assign busy    = (state_q == StRun);
    assign done    = (state_q == StDone);
    assign st_out1 = coll1_q;
    assign st_out2 = coll2_q;
    assign st_out3 = coll3_q;

endmodule
